// File: rtl/imm_pkg.sv
// Shared encodings for the immediate extender: mode codes and control field widths.
package imm_pkg;

  localparam int MODE_W  = 2;
  localparam int SHAMT_W = 2;

  localparam logic [MODE_W-1:0] IMM_ZEXT     = 2'd0;
  localparam logic [MODE_W-1:0] IMM_SEXT     = 2'd1;
  localparam logic [MODE_W-1:0] IMM_SEXT_SHL = 2'd2;
  localparam logic [MODE_W-1:0] IMM_LUI      = 2'd3;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extension: zero/sign extend, shifted sign extend with
// overflow detect, and load-upper placement. Zero latency, no flow control.
module imm_extend_core
  import imm_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]    imm_i,
  input  logic [MODE_W-1:0]  mode_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic [OUT_W-1:0]   data_o,
  output logic               ovf_o
);

  // Three guard bits cover the largest shift, so the wide value is exact.
  localparam int WIDE_W = OUT_W + 3;

  logic [WIDE_W-1:0] wide_sext;
  logic [WIDE_W-1:0] wide_shl;
  logic [2:0]        guard_bits;

  assign wide_sext  = WIDE_W'($signed(imm_i));
  assign wide_shl   = wide_sext << shamt_i;
  assign guard_bits = wide_shl[WIDE_W-1:OUT_W];

  always_comb begin
    data_o = '0;
    ovf_o  = 1'b0;
    case (mode_i)
      IMM_ZEXT: data_o = OUT_W'(imm_i);
      IMM_SEXT: data_o = wide_sext[OUT_W-1:0];
      IMM_SEXT_SHL: begin
        data_o = wide_shl[OUT_W-1:0];
        ovf_o  = (guard_bits != {3{wide_shl[OUT_W-1]}});
      end
      IMM_LUI:  data_o = OUT_W'(imm_i) << (OUT_W - IN_W);
      default: begin
        data_o = '0;
        ovf_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: one output register plus a one-entry skid buffer,
// 1-cycle latency, full throughput; in_ready depends only on registered state and rst.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_imm,
  input  logic [MODE_W-1:0]  in_mode,
  input  logic [SHAMT_W-1:0] in_shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_ovf,
  output logic [CNT_W-1:0]   xfer_cnt
);

  logic [OUT_W-1:0] core_dat;
  logic             core_ovf;

  logic             out_vld_q, out_vld_d;
  logic [OUT_W-1:0] out_dat_q, out_dat_d;
  logic             out_ovf_q, out_ovf_d;
  logic             skid_vld_q, skid_vld_d;
  logic [OUT_W-1:0] skid_dat_q, skid_dat_d;
  logic             skid_ovf_q, skid_ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic in_fire;
  logic out_fire;
  logic out_free;

  imm_extend_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .imm_i   (in_imm),
    .mode_i  (in_mode),
    .shamt_i (in_shamt),
    .data_o  (core_dat),
    .ovf_o   (core_ovf)
  );

  assign in_ready = !skid_vld_q && !rst;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_vld_q && out_ready;
  assign out_free = !out_vld_q || out_ready;

  always_comb begin
    out_vld_d  = out_vld_q;
    out_dat_d  = out_dat_q;
    out_ovf_d  = out_ovf_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    skid_ovf_d = skid_ovf_q;
    cnt_d      = out_fire ? cnt_q + CNT_W'(1) : cnt_q;

    if (out_free) begin
      // A parked skid entry is older than anything on the input, so it goes first.
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_dat_d  = skid_dat_q;
        out_ovf_d  = skid_ovf_q;
        skid_vld_d = 1'b0;
      end else if (in_fire) begin
        out_vld_d = 1'b1;
        out_dat_d = core_dat;
        out_ovf_d = core_ovf;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_vld_d = 1'b1;
      skid_dat_d = core_dat;
      skid_ovf_d = core_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      out_ovf_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
      skid_ovf_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
      out_ovf_q  <= out_ovf_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
      skid_ovf_q <= skid_ovf_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = out_vld_q;
  assign out_data  = out_dat_q;
  assign out_ovf   = out_ovf_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: default-width instance A and a narrow
// instance B (OUT_W=10, CNT_W=4) for overflow and counter wrap.
module tb_imm_extend_pipe;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Instance A: IN_W=8, OUT_W=16, CNT_W=16
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf;
  logic [7:0]  a_imm;
  logic [1:0]  a_mode, a_sh;
  logic [15:0] a_out_data, a_cnt;

  // Instance B: IN_W=8, OUT_W=10, CNT_W=4
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
  logic [7:0]  b_imm;
  logic [1:0]  b_mode, b_sh;
  logic [9:0]  b_out_data;
  logic [3:0]  b_cnt;

  logic [16:0] qa[$];
  logic [16:0] qb[$];

  imm_extend_pipe #(.IN_W(8), .OUT_W(16), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_imm(a_imm), .in_mode(a_mode), .in_shamt(a_sh),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_ovf(a_out_ovf), .xfer_cnt(a_cnt)
  );

  imm_extend_pipe #(.IN_W(8), .OUT_W(10), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_imm(b_imm), .in_mode(b_mode), .in_shamt(b_sh),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_ovf(b_out_ovf), .xfer_cnt(b_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Arithmetic reference: {ovf, data} with data masked to out_w bits.
  function automatic logic [16:0] model(input int out_w, input logic [1:0] mode,
                                        input logic [7:0] imm, input logic [1:0] sh);
    int s;
    int v;
    logic ovf;
    s   = imm[7] ? int'(imm) - 256 : int'(imm);
    v   = 0;
    ovf = 1'b0;
    case (mode)
      2'd0: v = int'(imm);
      2'd1: v = s;
      2'd2: begin
        v   = s * (1 << sh);
        ovf = (v >= (1 << (out_w - 1))) || (v < -(1 << (out_w - 1)));
      end
      default: v = int'(imm) << (out_w - 8);
    endcase
    return {ovf, 16'(v & ((1 << out_w) - 1))};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_a(input logic [1:0] mode, input logic [7:0] imm,
                        input logic [1:0] sh, input logic [16:0] exp);
    bit ok = 0;
    a_in_valid = 1'b1; a_mode = mode; a_imm = imm; a_sh = sh;
    for (int i = 0; i < 20; i++) begin
      if (a_in_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (ok) qa.push_back(exp);
    else check_eq("a_in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_b(input logic [1:0] mode, input logic [7:0] imm,
                        input logic [1:0] sh, input logic [16:0] exp);
    bit ok = 0;
    b_in_valid = 1'b1; b_mode = mode; b_imm = imm; b_sh = sh;
    for (int i = 0; i < 20; i++) begin
      if (b_in_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (ok) qb.push_back(exp);
    else check_eq("b_in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    qa.delete();
    qb.delete();
    rst = 1'b0;
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) check_eq("a_unexpected_out", {15'd0, a_out_ovf, a_out_data}, 32'h1ffff);
      else check_eq("a_out", {15'd0, a_out_ovf, a_out_data}, {15'd0, qa.pop_front()});
    end
    if (!rst && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) check_eq("b_unexpected_out", {15'd0, b_out_ovf, 6'd0, b_out_data}, 32'h1ffff);
      else check_eq("b_out", {15'd0, b_out_ovf, 6'd0, b_out_data}, {15'd0, qb.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [7:0]  sext_in  [5] = '{8'hF0, 8'h80, 8'h7F, 8'h00, 8'hFF};
  logic [15:0] sext_out [5] = '{16'hFFF0, 16'hFF80, 16'h007F, 16'h0000, 16'hFFFF};

  initial begin
    int start;
    logic [15:0] c0;
    logic [1:0]  m, s;
    logic [7:0]  v;

    rst = 1'b1;
    a_in_valid = 0; a_imm = 0; a_mode = 0; a_sh = 0; a_out_ready = 1;
    b_in_valid = 0; b_imm = 0; b_mode = 0; b_sh = 0; b_out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    check_eq("rst_out_data", {16'd0, a_out_data}, 32'd0);
    check_eq("rst_out_ovf", {31'd0, a_out_ovf}, 32'd0);
    check_eq("rst_xfer_cnt", {16'd0, a_cnt}, 32'd0);
    check_eq("rst_in_ready", {31'd0, a_in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_in_ready", {31'd0, a_in_ready}, 32'd1);

    // SEXT table, each result visible one edge after acceptance
    for (int i = 0; i < 5; i++) begin
      send_a(2'd1, sext_in[i], 2'd0, {1'b0, sext_out[i]});
      check_eq("sext_latency_vld", {31'd0, a_out_valid}, 32'd1);
      check_eq("sext_latency_dat", {15'd0, a_out_ovf, a_out_data}, {15'd0, 1'b0, sext_out[i]});
    end
    send_a(2'd0, 8'hF0, 2'd0, {1'b0, 16'h00F0});
    send_a(2'd3, 8'hAB, 2'd0, {1'b0, 16'hAB00});
    send_a(2'd2, 8'hFF, 2'd1, {1'b0, 16'hFFFE});
    a_in_valid = 0;
    repeat (2) begin @(posedge clk); #1; end

    // 100-transfer random stream at full rate
    c0 = a_cnt;
    start = cyc;
    for (int i = 0; i < 100; i++) begin
      m = 2'($urandom_range(0, 3)); v = 8'($urandom); s = 2'($urandom_range(0, 3));
      send_a(m, v, s, model(16, m, v, s));
    end
    check_eq("stream_cycles", 32'(cyc - start), 32'd100);
    a_in_valid = 0;
    repeat (2) begin @(posedge clk); #1; end
    check_eq("stream_cnt", {16'd0, a_cnt}, {16'd0, 16'(c0 + 16'd100)});

    // Backpressure: 0x01 held, 0x02 in skid, 0x03 held off
    pulse_reset();
    a_out_ready = 1'b0;
    send_a(2'd1, 8'h01, 2'd0, 17'h00001);
    send_a(2'd1, 8'h02, 2'd0, 17'h00002);
    check_eq("bp_in_ready_low", {31'd0, a_in_ready}, 32'd0);
    a_in_valid = 1'b1; a_imm = 8'h03; a_mode = 2'd1; a_sh = 2'd0;
    @(posedge clk); #1;
    check_eq("bp_in_ready_still_low", {31'd0, a_in_ready}, 32'd0);
    check_eq("bp_held_data", {16'd0, a_out_data}, 32'h0001);
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_second_vld", {31'd0, a_out_valid}, 32'd1);
    check_eq("bp_second_dat", {16'd0, a_out_data}, 32'h0002);
    send_a(2'd1, 8'h03, 2'd0, 17'h00003);
    a_in_valid = 1'b0;
    check_eq("bp_third_vld", {31'd0, a_out_valid}, 32'd1);
    check_eq("bp_third_dat", {16'd0, a_out_data}, 32'h0003);
    @(posedge clk); #1;
    check_eq("bp_cnt", {16'd0, a_cnt}, 32'd3);
    check_eq("bp_queue_drained", 32'(qa.size()), 32'd0);

    // Reset with output register and skid both occupied
    a_out_ready = 1'b0;
    send_a(2'd1, 8'h11, 2'd0, 17'h00011);
    send_a(2'd1, 8'h22, 2'd0, 17'h00022);
    a_in_valid = 1'b0;
    check_eq("mid_skid_full", {31'd0, a_in_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    qa.delete();
    check_eq("mid_rst_vld", {31'd0, a_out_valid}, 32'd0);
    check_eq("mid_rst_dat", {16'd0, a_out_data}, 32'd0);
    check_eq("mid_rst_cnt", {16'd0, a_cnt}, 32'd0);
    rst = 1'b0;
    a_out_ready = 1'b1;
    #1;
    check_eq("mid_rst_in_ready", {31'd0, a_in_ready}, 32'd1);
    send_a(2'd1, 8'h80, 2'd0, 17'h0FF80);
    a_in_valid = 1'b0;
    check_eq("mid_rst_sext80", {16'd0, a_out_data}, 32'hFF80);

    // Narrow instance: overflow detection and counter wrap
    send_b(2'd2, 8'h7F, 2'd3, {1'b1, 16'h03F8});
    send_b(2'd2, 8'h0F, 2'd3, {1'b0, 16'h0078});
    send_b(2'd2, 8'hC0, 2'd3, model(10, 2'd2, 8'hC0, 2'd3));
    b_in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    pulse_reset();
    for (int i = 0; i < 17; i++) begin
      send_b(2'd1, 8'(i), 2'd0, model(10, 2'd1, 8'(i), 2'd0));
    end
    b_in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check_eq("b_cnt_wrap", {28'd0, b_cnt}, 32'd1);
    check_eq("a_queue_empty", 32'(qa.size()), 32'd0);
    check_eq("b_queue_empty", 32'(qb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, pipelined immediate extender that replaces the fixed 8→16 sign extender in the processor datapath. It accepts an IN_W-bit immediate with a per-transfer mode and produces an OUT_W-bit result with one register stage. It supports zero-extend, sign-extend, shifted sign-extend with an overflow flag, and load-upper. Valid/ready handshakes on both sides, plus a one-entry skid buffer, let it sit between decode and execute without throughput loss under backpressure.

## Interface
- IN_W, 8, immediate input width (≥2)
- OUT_W, 16, result width (≥ IN_W)
- CNT_W, 16, width of transfer counter
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  input transfer offered
- in_ready  output  1  block can accept input
- in_imm  input  IN_W  raw immediate
- in_mode  input  2  operation: 0 ZEXT, 1 SEXT, 2 SEXT_SHL, 3 LUI
- in_shamt  input  2  left shift for SEXT_SHL (0..3), ignored otherwise
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_data  output  OUT_W  extended result
- out_ovf  output  1  SEXT_SHL result not representable in OUT_W signed
- xfer_cnt  output  CNT_W  count of completed output transfers

## Operation
- Transfers: input fires on in_valid & in_ready; output fires on out_valid & out_ready.
- ZEXT: out_data = {0…, in_imm}; out_ovf = 0.
- SEXT: out_data = in_imm replicated MSB to OUT_W; out_ovf = 0.
- SEXT_SHL: compute sext(in_imm) at OUT_W+3 bits, shift left by in_shamt, truncate to OUT_W. out_ovf = 1 iff the discarded upper bits are not all equal to bit OUT_W-1 of the truncated result.
- LUI: out_data = in_imm << (OUT_W-IN_W), low bits zero; out_ovf = 0.
- Storage: output register (out_valid/out_data/out_ovf) and one skid entry (skid_valid, data, ovf).
- Input fires while the output register is empty or drains this cycle: the result goes to the output register.
- Input fires while the output register is held (out_valid & !out_ready): the result goes to the skid entry.
- When the output drains and skid_valid: the skid contents move to the output register next cycle, and skid_valid clears.
- in_ready = !skid_valid & !rst; registered state only, with no combinational path from out_ready.
- xfer_cnt increments by 1 on each output fire and wraps at 2^CNT_W-1 → 0.
- Order is strictly preserved, with no loss or duplication.

## Timing
- Reset values: out_valid 0, out_data 0, out_ovf 0, skid_valid 0, xfer_cnt 0; in_ready 0 while rst high, 1 in the first cycle after.
- Latency is 1 cycle: input fired in cycle N gives out_valid in N+1 (empty pipe).
- Throughput is 1 transfer/cycle while out_ready stays high.
- Under stall, out_data and out_ovf hold stable until the output fires.
- Backpressure: the second accepted input during a stall fills skid; in_ready drops the next cycle.
- Simultaneous output fire + input fire with skid full is impossible, because in_ready is 0.
- Simultaneous output fire + input fire with skid empty: the new result replaces the output register the same edge.
- Reset mid-operation flushes the output register and skid and clears xfer_cnt on that edge; in-flight data is discarded.

## Structure
- Package imm_pkg: mode localparams IMM_ZEXT/IMM_SEXT/IMM_SEXT_SHL/IMM_LUI, mode width constant 2, shamt width 2.
- Sub-module imm_extend_core: purely combinational mode/shift/overflow logic (in_imm, mode, shamt → data, ovf), parametrised by IN_W/OUT_W.
- Top: handshake, skid buffer, counter.

## Test plan
- Default params, SEXT of 0xF0, 0x80, 0x7F, 0x00, 0xFF → 0xFFF0, 0xFF80, 0x007F, 0x0000, 0xFFFF, each 1 cycle after acceptance, out_ovf 0.
- ZEXT 0xF0 → 0x00F0; LUI 0xAB → 0xAB00; SEXT_SHL 0xFF with shamt 1 → 0xFFFE, ovf 0.
- OUT_W=10, SEXT_SHL: 0x7F with shamt 3 → out_data 0x3F8, out_ovf 1. Same run: 0x0F with shamt 3 → 0x078, ovf 0.
- Backpressure: out_ready low for 3 cycles while streaming SEXT 0x01, 0x02, 0x03:
  - 0x01 is held in the output register, 0x02 goes to skid, in_ready is 0 and 0x03 is held off.
  - After out_ready rises, outputs are 0x0001, 0x0002, 0x0003 on consecutive cycles; xfer_cnt = 3.
- Continuous stream of 100 transfers with out_ready held 1 → one output per cycle, xfer_cnt = 100. With CNT_W=4, 17 transfers → xfer_cnt = 1 (wrap).
- Assert rst for 1 cycle while out_valid=1 and skid full → next cycle out_valid 0, out_data 0, xfer_cnt 0, in_ready 1 after rst falls; subsequent SEXT 0x80 → 0xFF80.
